// File: rtl/multi_channel_read_arbiter.sv
// rtl/multi_channel_read_arbiter.sv - burst/pause read arbiter draining NUM_CH sample FIFOs into the Ethernet packetiser
module multi_channel_read_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int SEL_W     = $clog2(NUM_CH),
  parameter int BURST_LEN = 1024,
  parameter int PAUSE_LEN = 8192,
  parameter int RR_MODE   = 0,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [NUM_CH-1:0] empty,
  input  logic              eth_ready,
  output logic [NUM_CH-1:0] rd_en,
  output logic [SEL_W-1:0]  sel,
  output logic              eth_en,
  output logic              busy,
  output logic              burst_done
);

  // Terminal counts; a zero pause never enters PAUSE, so its terminal value is unused then.
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'((PAUSE_LEN > 0) ? PAUSE_LEN - 1 : 0);
  localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(NUM_CH - 1);
  localparam logic [SEL_W:0]   NUM_CH_X   = (SEL_W + 1)'(NUM_CH);
  localparam bit               HAS_PAUSE  = (PAUSE_LEN != 0);

  // Parameter legality is rejected at elaboration rather than misbehaving silently.
  generate
    if (NUM_CH < 2) begin : g_bad_num_ch
      $error("multi_channel_read_arbiter: NUM_CH must be >= 2");
    end
    if ((longint'(1) << SEL_W) < longint'(NUM_CH)) begin : g_bad_sel_w
      $error("multi_channel_read_arbiter: SEL_W too narrow for NUM_CH");
    end
    if (BURST_LEN < 1) begin : g_bad_burst
      $error("multi_channel_read_arbiter: BURST_LEN must be >= 1");
    end
    if (PAUSE_LEN < 0) begin : g_bad_pause
      $error("multi_channel_read_arbiter: PAUSE_LEN must be >= 0");
    end
    if ((longint'(BURST_LEN) - 1) >= (longint'(1) << CNT_W) ||
        (longint'(PAUSE_LEN) - 1) >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
      $error("multi_channel_read_arbiter: CNT_W cannot hold max(BURST_LEN, PAUSE_LEN)-1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [SEL_W-1:0] r_rr_ptr;
  logic [SEL_W-1:0] w_rr_ptr_nxt;
  logic             r_burst_done;
  logic             w_burst_done_nxt;

  logic [SEL_W-1:0] w_cand;
  logic             w_found;
  logic             w_all_empty;
  logic             w_beat;

  assign w_all_empty = &empty;
  assign w_beat      = (r_state == S_READ) && !w_all_empty && eth_ready;

  // First non-empty channel, scanning from 0 (fixed priority) or from r_rr_ptr with wrap (round-robin).
  always_comb begin : p_cand
    logic [SEL_W:0] idx;
    idx     = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (RR_MODE != 0) ? ({1'b0, r_rr_ptr} + (SEL_W + 1)'(k)) : (SEL_W + 1)'(k);
      if (idx >= NUM_CH_X) begin
        idx = idx - NUM_CH_X;
      end
      if (!w_found && !empty[idx[SEL_W-1:0]]) begin
        w_cand  = idx[SEL_W-1:0];
        w_found = 1'b1;
      end
    end
  end

  // Read strobe and mux address follow the current candidate; nothing is read on stall cycles.
  always_comb begin : p_outputs
    rd_en = '0;
    if (w_beat) begin
      rd_en[w_cand] = 1'b1;
    end
    sel = ((r_state != S_IDLE) && !w_all_empty) ? w_cand : '0;
  end

  assign eth_en     = w_beat;
  assign busy       = (r_state != S_IDLE);
  assign burst_done = r_burst_done;

  // Next-state: an all-empty source set always drops back to IDLE; beats and pause cycles advance the counter.
  always_comb begin : p_next
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_burst_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !w_all_empty) begin
          w_state_nxt = S_READ;
          w_cnt_nxt   = '0;
        end
      end
      S_READ: begin
        if (w_all_empty) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_beat) begin
          if (r_cnt == BURST_LAST) begin
            w_cnt_nxt        = '0;
            w_burst_done_nxt = 1'b1;
            w_state_nxt      = HAS_PAUSE ? S_PAUSE : S_READ;
            if (RR_MODE != 0) begin
              w_rr_ptr_nxt = (w_cand == LAST_CH) ? '0 : w_cand + SEL_W'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_PAUSE: begin
        if (w_all_empty) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == PAUSE_LAST) begin
          w_state_nxt = S_READ;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter, round-robin pointer and burst_done pulse registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_rr_ptr     <= '0;
      r_burst_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_burst_done <= w_burst_done_nxt;
    end
  end

endmodule
